// File: rtl/spart_pkg.sv
// Shared SPART types and constants: receiver FSM states, default framing
// parameters and the bus ioaddr map.
package spart_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    localparam int SPART_OVERSAMPLE = 16;
    localparam int SPART_DATA_BITS  = 8;

    localparam logic [1:0] IOADDR_DATA   = 2'b00;
    localparam logic [1:0] IOADDR_STATUS = 2'b01;
    localparam logic [1:0] IOADDR_DB_LO  = 2'b10;
    localparam logic [1:0] IOADDR_DB_HI  = 2'b11;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/spart_rx_if.sv
// Receive-side signal bundle between the SPART receiver (slave) and the
// baud generator / bus logic that drive and consume it (master).
interface spart_rx_if #(
    parameter int DATA_BITS = spart_pkg::SPART_DATA_BITS
);
    logic                 rx_baud_en;
    logic                 rxd;
    logic                 rda_clr;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rda;
    logic                 framing_err;
    logic                 overrun_err;

    modport master (
        output rx_baud_en, rxd, rda_clr,
        input  rx_data, rda, framing_err, overrun_err
    );

    modport slave (
        input  rx_baud_en, rxd, rda_clr,
        output rx_data, rda, framing_err, overrun_err
    );
endinterface

// File: rtl/spart_sync2.sv
// Two-flop synchroniser for an asynchronous SPART input; the reset value is a
// parameter so idle-high lines come out of reset already idle.
module spart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_q    <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/spart_rx.sv
// SPART 8N1 receiver driven by the oversampled receive_baud enable.
// Define SPART_RX_MAJORITY_EN for 2-of-3 majority voting around each mid-bit.
module spart_rx
    import spart_pkg::*;
#(
    parameter int DATA_BITS  = SPART_DATA_BITS,
    parameter int OVERSAMPLE = SPART_OVERSAMPLE
) (
    input  logic       clk,
    input  logic       rst,
    spart_rx_if.slave  bus
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    // After the start decision the tick counter restarts, so every later
    // decision lands one full bit period on, at OVERSAMPLE-1.
    localparam logic [TW-1:0] BIT_DEC  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    logic w_rxs;
    logic w_bit;

    spart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (bus.rxd),
        .o_q (w_rxs)
    );

`ifdef SPART_RX_MAJORITY_EN
    localparam logic [TW-1:0] START_DEC = TW'(OVERSAMPLE / 2);

    logic [1:0] r_hist;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist <= 2'b11;
        end else if (bus.rx_baud_en) begin
            r_hist <= {r_hist[0], w_rxs};
        end
    end

    assign w_bit = maj3(r_hist[1], r_hist[0], w_rxs);
`else
    localparam logic [TW-1:0] START_DEC = TW'(OVERSAMPLE / 2 - 1);

    assign w_bit = w_rxs;
`endif

    rx_state_t            r_state;
    logic [TW-1:0]        r_tick;
    logic [BW-1:0]        r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rda;
    logic                 r_framing_err;
    logic                 r_overrun_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= RX_IDLE;
            r_tick        <= '0;
            r_bit         <= '0;
            r_shift       <= '0;
            r_rx_data     <= '0;
            r_rda         <= 1'b0;
            r_framing_err <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            // A read clears status; a commit later in this block overrides it.
            if (bus.rda_clr) begin
                r_rda         <= 1'b0;
                r_framing_err <= 1'b0;
                r_overrun_err <= 1'b0;
            end

            if (bus.rx_baud_en) begin
                case (r_state)
                    RX_IDLE: begin
                        if (!w_rxs) begin
                            r_state <= RX_START;
                            r_tick  <= '0;
                        end
                    end
                    RX_START: begin
                        if (r_tick == START_DEC) begin
                            r_tick <= '0;
                            r_bit  <= '0;
                            r_state <= w_bit ? RX_IDLE : RX_DATA;
                        end else begin
                            r_tick <= r_tick + TW'(1);
                        end
                    end
                    RX_DATA: begin
                        if (r_tick == BIT_DEC) begin
                            r_tick  <= '0;
                            r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
                            if (r_bit == LAST_BIT) begin
                                r_state <= RX_STOP;
                            end else begin
                                r_bit <= r_bit + BW'(1);
                            end
                        end else begin
                            r_tick <= r_tick + TW'(1);
                        end
                    end
                    RX_STOP: begin
                        if (r_tick == BIT_DEC) begin
                            r_tick  <= '0;
                            r_state <= RX_IDLE;
                            if (!r_rda || bus.rda_clr) begin
                                r_rx_data     <= r_shift;
                                r_rda         <= 1'b1;
                                r_framing_err <= ~w_bit;
                            end else begin
                                r_overrun_err <= 1'b1;
                            end
                        end else begin
                            r_tick <= r_tick + TW'(1);
                        end
                    end
                    default: r_state <= RX_IDLE;
                endcase
            end
        end
    end

    assign bus.rx_data     = r_rx_data;
    assign bus.rda         = r_rda;
    assign bus.framing_err = r_framing_err;
    assign bus.overrun_err = r_overrun_err;
endmodule
